// File: rtl/rr_arbiter32.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter32
// Description : 32-requester round-robin arbiter with a binary grant index,
//               a release handshake and a watchdog that reclaims stuck grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter32 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    input  logic        done,
    output logic        gnt_valid,
    output logic [4:0]  gnt_idx,
    output logic        timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter value seen during the last cycle a grant may remain valid.
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic [4:0]  gnt_idx_q, gnt_idx_d;
    logic        timeout_q, timeout_d;

    logic        w_found;
    logic [4:0]  w_sel_idx;

    // Scan from ptr upward; 5-bit index arithmetic wraps 31 back to 0.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = ptr_q;
        for (int i = 0; i < 32; i++) begin
            if (!w_found && req[ptr_q + 5'(i)]) begin
                w_found   = 1'b1;
                w_sel_idx = ptr_q + 5'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_valid_d = 1'b0;
                if (w_found) begin
                    state_d     = ST_GRANT;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = w_sel_idx;
                    cnt_d       = 8'd0;
                end
            end
            ST_GRANT: begin
                // A done in the final watchdog cycle wins: plain release, no pulse.
                if (done || (cnt_q == C_HOLD_LAST)) begin
                    state_d     = ST_IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 5'd1;
                    cnt_d       = 8'd0;
                    timeout_d   = ~done;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 5'd0;
            cnt_q       <= 8'd0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= 5'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter32.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter32
// Description : Scoreboard bench for rr_arbiter32 with directed grant vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter32;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        done;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int len;
        int to;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter32 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per grant and checks index, length, pulse.
    initial begin
        exp_t cur;
        bit   cur_live;
        bit   prev_valid;
        int   hold;
        cur_live   = 1'b0;
        prev_valid = 1'b0;
        hold       = 0;
        forever begin
            @(negedge clk);
            if (gnt_valid && !prev_valid) begin
                hold = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur_live = 1'b0;
                    $display("FAIL unexpected_grant actual=%0d expected=none at %0t", gnt_idx, $time);
                end else begin
                    cur      = exp_q.pop_front();
                    cur_live = 1'b1;
                    chk("grant_idx", int'(gnt_idx), cur.idx);
                end
            end else if (gnt_valid) begin
                hold++;
            end else if (prev_valid && cur_live) begin
                chk("hold_len", hold, cur.len);
                chk("timeout_on_release", int'(timeout), cur.to);
                cur_live = 1'b0;
            end
            if (timeout && !(prev_valid && !gnt_valid)) begin
                chk("spurious_timeout", int'(timeout), 0);
            end
            prev_valid = gnt_valid;
        end
    end

    // One grant from an idle arbiter; done raised in grant cycle done_cyc (0 = never).
    task automatic grant_one(input logic [31:0] r, input int done_cyc,
                             input int exp_idx, input int exp_len, input int exp_to);
        int n;
        exp_q.push_back('{exp_idx, exp_len, exp_to});
        req  = r;
        done = 1'b0;
        @(negedge clk);
        chk("req_to_grant_latency", int'(gnt_valid), 1);
        n = 0;
        while (!gnt_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!gnt_valid) begin
            chk("grant_wait_expired", 0, 1);
            req = '0;
            return;
        end
        req = '0;
        n   = 1;
        while (n < 300) begin
            if (n == done_cyc) done = 1'b1;
            @(negedge clk);
            if (!gnt_valid) break;
            n++;
        end
        if (gnt_valid) chk("release_wait_expired", 0, 1);
        done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int g;
        int n;
        bit p;
        rst_n = 1'b1;
        req   = 32'hFFFF_FFFF;
        done  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async_gnt_valid", int'(gnt_valid), 0);
        chk("reset_async_gnt_idx",   int'(gnt_idx),   0);
        chk("reset_async_timeout",   int'(timeout),   0);
        repeat (3) @(negedge clk);
        chk("reset_held_gnt_valid", int'(gnt_valid), 0);

        // Full rotation 0..31,0 with done asserted throughout.
        for (int i = 0; i < 33; i++) exp_q.push_back('{i % 32, 1, 0});
        rst_n = 1'b1;
        req   = 32'hFFFF_FFFF;
        done  = 1'b1;
        g = 0;
        p = 1'b0;
        n = 0;
        while (g < 33 && n < 200) begin
            @(negedge clk);
            if (gnt_valid && !p) g++;
            p = gnt_valid;
            n++;
        end
        chk("rotation_grant_count", g, 33);
        req = '0;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);

        // Single requester, release on third grant cycle; pointer then 6.
        grant_one(32'h1 << 5, 3, 5, 3, 0);
        grant_one((32'h1 << 5) | (32'h1 << 6), 1, 6, 1, 0);

        // Park pointer at 3, then wrap between 30 and 2.
        grant_one(32'h1 << 2, 1, 2, 1, 0);
        grant_one((32'h1 << 2) | (32'h1 << 30), 1, 30, 1, 0);
        grant_one((32'h1 << 2) | (32'h1 << 30), 1, 2, 1, 0);
        grant_one((32'h1 << 2) | (32'h1 << 30), 1, 30, 1, 0);

        // Watchdog expiry, then pointer continues from 8.
        grant_one(32'h1 << 7, 0, 7, 8, 1);
        grant_one((32'h1 << 7) | (32'h1 << 9), 1, 9, 1, 0);

        // done in the last watchdog cycle is a normal release.
        grant_one(32'h1 << 1, 8, 1, 8, 0);

        // done while idle has no effect.
        done = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_done_gnt_valid", int'(gnt_valid), 0);
        chk("idle_done_timeout",   int'(timeout),   0);
        done = 1'b0;

        // Asynchronous reset in the middle of a grant to requester 12.
        exp_q.push_back('{12, 2, 0});
        req = 32'h1 << 12;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midgrant_reset_gnt_valid", int'(gnt_valid), 0);
        chk("midgrant_reset_gnt_idx",   int'(gnt_idx),   0);
        chk("midgrant_reset_timeout",   int'(timeout),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        grant_one((32'h1 << 3) | (32'h1 << 20), 1, 3, 1, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter32.md
RR_ARBITER32 -- requirements
Module: rr_arbiter32

Purpose: 32-requester round-robin arbiter; its gnt_idx drives the 5-bit input of the 5-to-32 decoder, which expands it into a one-hot grant.

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 8, max cycles a grant stays valid without done (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: req  input  32  request vector; bit i = requester i.
REQ-005 SHALL have port: done  input  1  current grantee releases the grant.
REQ-006 SHALL have port: gnt_valid  output  1  gnt_idx holds a live grant.
REQ-007 SHALL have port: gnt_idx  output  5  index of granted requester, binary-encoded.
REQ-008 SHALL have port: timeout  output  1  one-cycle pulse on watchdog release.

Function
REQ-009 SHALL implement two states: IDLE and GRANT; all outputs registered.
REQ-010 SHALL hold a 5-bit priority pointer ptr; search order ptr, ptr+1, ..., 31, 0, ..., ptr-1.
REQ-011 In IDLE with req != 0, SHALL select the first set req bit in search order, enter GRANT at the next edge, gnt_valid=1, gnt_idx=selected index, hold counter cleared.
REQ-012 Req-to-grant latency SHALL be exactly 1 cycle.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE; gnt_valid=0; gnt_idx keeps its last value.
REQ-014 In GRANT, gnt_idx SHALL stay stable regardless of req changes, including deassertion of the grantee's own req bit.
REQ-015 In GRANT with done=1 at an edge: return to IDLE; gnt_valid=0; ptr = gnt_idx+1 mod 32 (31 wraps to 0).
REQ-016 In GRANT with done=0, hold counter SHALL increment each cycle; gnt_valid SHALL stay high at most MAX_HOLD cycles.
REQ-017 When gnt_valid has been high for MAX_HOLD cycles with no done, SHALL release as in REQ-015 and assert timeout=1 for exactly the first cycle gnt_valid=0.
REQ-018 If done=1 in the final watchdog cycle, SHALL treat it as a normal release; timeout stays 0.
REQ-019 done in IDLE SHALL be ignored.
REQ-020 At least one IDLE cycle SHALL occur between consecutive grants; no same-edge re-grant.
REQ-021 Counter width SHALL be 8 bits; no wrap is reachable because MAX_HOLD <= 255.

Reset
REQ-022 rst_n low SHALL immediately, without clk, force: state=IDLE, ptr=0, counter=0, gnt_valid=0, gnt_idx=0, timeout=0.
REQ-023 Reset mid-GRANT SHALL abort the grant with no timeout pulse; the first grant after reset SHALL search from index 0.
REQ-024 The first rising edge after rst_n rises SHALL evaluate req per REQ-011.

Verification
REQ-025 Reset: rst_n=0 with req=32'hFFFFFFFF -> gnt_valid=0, gnt_idx=0, timeout=0 with no clk edge.
REQ-026 Single requester: req=bit 5, done=1 on third GRANT cycle -> gnt_idx=5 one cycle after req; gnt_valid high exactly 3 cycles; next grant searches from 6.
REQ-027 Full rotation: req=32'hFFFFFFFF, done=1 every GRANT cycle -> gnt_idx sequence 0,1,2,...,31,0; one IDLE cycle between grants.
REQ-028 Wrap: req = bits 2 and 30, ptr=3 -> grants 30, then 2 (wrap through 31->0), then 30.
REQ-029 Watchdog: MAX_HOLD=8, req=bit 7, done held 0 -> gnt_valid high 8 cycles; timeout=1 for one cycle as gnt_valid falls; next grant searches from 8.
REQ-030 Async reset mid-grant with gnt_idx=12 -> outputs 0 immediately; after release with req = bits 3 and 20 -> first grant gnt_idx=3.
